// File: rtl/xbar_pkg.sv
// Shared crossbar types: command and scheduler-state enums, transaction struct and width helper.
// Imported by every slave scheduler and by the reusable round-robin picker.
package xbar_pkg;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_RESP
  } sched_state_e;

  localparam int XBAR_DATA_W = 32;
  localparam int XBAR_AW     = 30;

  // Index width that stays at least one bit wide even for a single-entry vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    cmd_e                   cmd;
    logic [XBAR_AW-1:0]     addr;
    logic [XBAR_DATA_W-1:0] data;
  } tx_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester strictly after i_last, wrapping around.
// Shared by all crossbar arbiters.
module rr_pick
  import xbar_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [IW-1:0] o_winner,
  output logic          o_any
);

  logic [IW-1:0] w_idx;

  // Scan from the farthest candidate back to the nearest so the nearest requester wins.
  always_comb begin
    o_winner = '0;
    w_idx    = '0;
    for (int k = N; k >= 1; k--) begin
      w_idx = IW'((int'(i_last) + k) % N);
      if (i_req[w_idx]) o_winner = w_idx;
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/xbar_slave_scheduler.sv
// Per-slave-port scheduler: round-robin grant of queued master cells, slave req/ack/resp
// handshake, routing of ack/resp/rdata back to the owner, and a watchdog abort.
module xbar_slave_scheduler
  import xbar_pkg::*;
#(
  parameter  int MASTERS = 4,
  parameter  int AW      = 30,
  parameter  int TIMEOUT = 256,
  localparam int IW      = idx_width(MASTERS),
  localparam int WDW     = $clog2(TIMEOUT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MASTERS-1:0]    m_valid,
  input  logic [MASTERS-1:0]    m_cmd,
  input  logic [MASTERS*AW-1:0] m_addr,
  input  logic [MASTERS*32-1:0] m_wdata,
  output logic [MASTERS-1:0]    m_pop,
  output logic                  s_req,
  output logic                  s_cmd,
  output logic [AW-1:0]         s_addr,
  output logic [31:0]           s_wdata,
  input  logic                  s_ack,
  input  logic                  s_resp,
  input  logic [31:0]           s_rdata,
  output logic [IW-1:0]         gnt_id,
  output logic                  busy,
  output logic [MASTERS-1:0]    ack_out,
  output logic [MASTERS-1:0]    resp_out,
  output logic [MASTERS-1:0]    err_out,
  output logic [31:0]           rdata_out
);

  sched_state_e r_state, w_nextState;

  logic [IW-1:0]      r_lastGnt, r_gnt, w_winner;
  logic               w_any;
  logic [WDW-1:0]     r_wdog;
  logic               w_expired, w_grant, w_ackEv, w_respEv, w_errEv;
  logic [MASTERS-1:0] w_winHot, w_gntHot;

  logic               r_sReq, r_cmd;
  logic [MASTERS-1:0] r_mPop, r_ackOut, r_respOut, r_errOut;
  logic [AW-1:0]      r_addr;
  logic [31:0]        r_wdata, r_rdata;

  rr_pick #(.N(MASTERS)) u_pick (
    .i_req    (m_valid),
    .i_last   (r_lastGnt),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_expired = (r_wdog == WDW'(TIMEOUT - 1));
  assign w_winHot  = MASTERS'(1) << w_winner;
  assign w_gntHot  = MASTERS'(1) << r_gnt;

  // Slave events always beat a watchdog expiry landing in the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_ackEv     = 1'b0;
    w_respEv    = 1'b0;
    w_errEv     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant     = 1'b1;
          w_nextState = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (s_ack) begin
          w_ackEv = 1'b1;
          if (s_resp) begin
            w_respEv    = 1'b1;
            w_nextState = IDLE;
          end else begin
            w_nextState = WAIT_RESP;
          end
        end else if (w_expired) begin
          w_errEv     = 1'b1;
          w_nextState = IDLE;
        end
      end
      WAIT_RESP: begin
        if (s_resp) begin
          w_respEv    = 1'b1;
          w_nextState = IDLE;
        end else if (w_expired) begin
          w_errEv     = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Watchdog restarts on every state change so each wait phase gets its own budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_wdog <= '0;
    else if (w_nextState != r_state)   r_wdog <= '0;
    else if (r_state != IDLE)          r_wdog <= r_wdog + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sReq    <= 1'b0;
      r_mPop    <= '0;
      r_cmd     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_gnt     <= '0;
      r_lastGnt <= IW'(MASTERS - 1);
      r_ackOut  <= '0;
      r_respOut <= '0;
      r_errOut  <= '0;
      r_rdata   <= '0;
    end else begin
      r_sReq    <= w_grant;
      r_mPop    <= w_grant  ? w_winHot : '0;
      r_ackOut  <= w_ackEv  ? w_gntHot : '0;
      r_respOut <= w_respEv ? w_gntHot : '0;
      r_errOut  <= w_errEv  ? w_gntHot : '0;
      if (w_grant) begin
        r_cmd     <= m_cmd[w_winner];
        r_addr    <= m_addr[int'(w_winner) * AW +: AW];
        r_gnt     <= w_winner;
        r_lastGnt <= w_winner;
        if (m_cmd[w_winner] == CMD_WRITE) r_wdata <= m_wdata[int'(w_winner) * 32 +: 32];
      end
      if (w_respEv && (r_cmd == CMD_READ)) r_rdata <= s_rdata;
    end
  end

  assign m_pop     = r_mPop;
  assign s_req     = r_sReq;
  assign s_cmd     = r_cmd;
  assign s_addr    = r_addr;
  assign s_wdata   = r_wdata;
  assign gnt_id    = r_gnt;
  assign busy      = (r_state != IDLE);
  assign ack_out   = r_ackOut;
  assign resp_out  = r_respOut;
  assign err_out   = r_errOut;
  assign rdata_out = r_rdata;

endmodule

// File: tb/tb_xbar_slave_scheduler.sv
// Scoreboard bench for xbar_slave_scheduler: the driver predicts every output event from a
// transaction-level model and queues it; a negedge monitor pops and compares as events appear.
module tb_xbar_slave_scheduler;

  localparam int M  = 4;
  localparam int AW = 30;
  localparam int TO = 8;

  localparam int K_GRANT = 0;
  localparam int K_ACK   = 1;
  localparam int K_RESP  = 2;
  localparam int K_ERR   = 3;

  logic            clk;
  logic            rst_n;
  logic [M-1:0]    m_valid, m_cmd, m_pop, ack_out, resp_out, err_out;
  logic [M*AW-1:0] m_addr;
  logic [M*32-1:0] m_wdata;
  logic            s_req, s_cmd, s_ack, s_resp, busy;
  logic [AW-1:0]   s_addr;
  logic [31:0]     s_wdata, s_rdata, rdata_out;
  logic [1:0]      gnt_id;

  xbar_slave_scheduler #(.MASTERS(M), .AW(AW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_valid   (m_valid),
    .m_cmd     (m_cmd),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_pop     (m_pop),
    .s_req     (s_req),
    .s_cmd     (s_cmd),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_ack     (s_ack),
    .s_resp    (s_resp),
    .s_rdata   (s_rdata),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .ack_out   (ack_out),
    .resp_out  (resp_out),
    .err_out   (err_out),
    .rdata_out (rdata_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;
    int          master;
    int          cyc;
    logic        cmd;
    logic [AW-1:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
  } exp_t;

  exp_t expQ[$];

  // Transaction-level model state
  int          lastGnt;
  logic [31:0] modelRdata, modelWdata;
  logic        cellCmd[M];
  logic [AW-1:0] cellAddr[M];
  logic [31:0] cellData[M];
  logic [31:0] slaveRdata;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".ctrl"}, {s_req, m_pop, s_cmd, gnt_id, busy, ack_out, resp_out, err_out}, 64'd0);
    checkOutput({tag, ".s_addr"}, s_addr, 64'd0);
    checkOutput({tag, ".s_wdata"}, s_wdata, 64'd0);
    checkOutput({tag, ".rdata_out"}, rdata_out, 64'd0);
  endtask

  function automatic int pickRR(input logic [M-1:0] v, input int last);
    for (int off = 1; off <= M; off++) begin
      if (v[(last + off) % M]) return (last + off) % M;
    end
    return -1;
  endfunction

  function automatic exp_t mkEv(input int kind, input int master, input int c, input logic b);
    exp_t e;
    e.kind   = kind;
    e.master = master;
    e.cyc    = c;
    e.cmd    = cellCmd[master];
    e.addr   = cellAddr[master];
    e.wdata  = modelWdata;
    e.rdata  = modelRdata;
    e.busy   = b;
    return e;
  endfunction

  function automatic logic [M-1:0] hot(input int i);
    logic [M-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic handleEvent(input int kind);
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpectedEvent: got kind %0d, expected no event (cycle %0d)", kind, cyc);
      return;
    end
    e = expQ.pop_front();
    checkOutput("eventKind", kind, e.kind);
    checkOutput("eventCycle", cyc, e.cyc);
    checkOutput("busy", busy, e.busy);
    case (kind)
      K_GRANT: begin
        checkOutput("s_req", s_req, 1);
        checkOutput("m_pop", m_pop, hot(e.master));
        checkOutput("gnt_id", gnt_id, e.master);
        checkOutput("s_cmd", s_cmd, e.cmd);
        checkOutput("s_addr", s_addr, e.addr);
        checkOutput("s_wdata", s_wdata, e.wdata);
      end
      K_ACK:  checkOutput("ack_out", ack_out, hot(e.master));
      K_RESP: begin
        checkOutput("resp_out", resp_out, hot(e.master));
        checkOutput("rdata_out", rdata_out, e.rdata);
      end
      default: checkOutput("err_out", err_out, hot(e.master));
    endcase
  endtask

  // Monitor: any visible output event must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_req || (m_pop != '0)) handleEvent(K_GRANT);
      if (ack_out != '0)          handleEvent(K_ACK);
      if (resp_out != '0)         handleEvent(K_RESP);
      if (err_out != '0)          handleEvent(K_ERR);
    end
  end

  task automatic randomizeCells();
    for (int i = 0; i < M; i++) begin
      cellCmd[i]  = 1'($urandom_range(0, 1));
      cellAddr[i] = AW'($urandom);
      cellData[i] = $urandom;
    end
    slaveRdata = $urandom;
  endtask

  task automatic driveJunk();
    for (int i = 0; i < M; i++) begin
      m_cmd[i]             = 1'($urandom_range(0, 1));
      m_addr[i*AW +: AW]   = AW'($urandom);
      m_wdata[i*32 +: 32]  = $urandom;
    end
  endtask

  task automatic modelReset();
    lastGnt    = M - 1;
    modelRdata = '0;
    modelWdata = '0;
  endtask

  task automatic doReset();
    rst_n   = 1'b0;
    m_valid = '0;
    s_ack   = 1'b0;
    s_resp  = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    expQ.delete();
    modelReset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // mode 0: ack then resp, 1: ack+resp together, 2: no ack, 3: ack but no resp,
  // 4: ack then reset while waiting for resp. Called on a negedge with the DUT idle.
  task automatic applyStimulus(input logic [M-1:0] valid, input int mode, input int d1,
                               input int d2, input bit keep);
    int G, A, P, endC, w, c;
    if (!keep) randomizeCells();
    G = cyc + 1;
    w = pickRR(valid, lastGnt);
    lastGnt = w;
    if (cellCmd[w]) modelWdata = cellData[w];
    expQ.push_back(mkEv(K_GRANT, w, G, 1'b1));
    A = G + d1;
    P = A + 1 + d2;
    case (mode)
      0: begin
        expQ.push_back(mkEv(K_ACK, w, A + 1, 1'b1));
        if (!cellCmd[w]) modelRdata = slaveRdata;
        expQ.push_back(mkEv(K_RESP, w, P + 1, 1'b0));
        endC = P + 1;
      end
      1: begin
        expQ.push_back(mkEv(K_ACK, w, A + 1, 1'b0));
        if (!cellCmd[w]) modelRdata = slaveRdata;
        expQ.push_back(mkEv(K_RESP, w, A + 1, 1'b0));
        endC = A + 1;
      end
      2: begin
        expQ.push_back(mkEv(K_ERR, w, G + TO, 1'b0));
        endC = G + TO;
      end
      3: begin
        expQ.push_back(mkEv(K_ACK, w, A + 1, 1'b1));
        expQ.push_back(mkEv(K_ERR, w, A + 1 + TO, 1'b0));
        endC = A + 1 + TO;
      end
      default: begin
        expQ.push_back(mkEv(K_ACK, w, A + 1, 1'b1));
        endC = A + 2;
      end
    endcase
    m_valid = valid;
    for (int i = 0; i < M; i++) begin
      m_cmd[i]            = cellCmd[i];
      m_addr[i*AW +: AW]  = cellAddr[i];
      m_wdata[i*32 +: 32] = cellData[i];
    end
    while (1) begin
      @(negedge clk);
      c       = cyc;
      m_valid = '0;
      driveJunk();
      s_rdata = $urandom;
      s_ack   = 1'b0;
      s_resp  = 1'b0;
      case (mode)
        0: begin
          s_ack  = (c == A) || ((c > A) && (c <= P) && ($urandom_range(0, 1) == 1));
          s_resp = (c == P);
          if (c == P) s_rdata = slaveRdata;
        end
        1: begin
          s_ack  = (c == A);
          s_resp = (c == A);
          if (c == A) s_rdata = slaveRdata;
        end
        3:       s_ack = (c == A) || ((c > A) && ($urandom_range(0, 1) == 1));
        4:       s_ack = (c == A);
        default: s_ack = 1'b0;
      endcase
      if (c >= endC) begin
        s_ack  = 1'b0;
        s_resp = 1'b0;
        if (mode == 4) begin
          #2 rst_n = 1'b0;
          #1 checkAllZero("midOpReset");
          checkOutput("pendingAtReset", expQ.size(), 0);
          expQ.delete();
          modelReset();
          @(negedge clk);
          rst_n = 1'b1;
        end
        break;
      end
    end
    @(negedge clk);
  endtask

  function automatic int pickDelay();
    return ($urandom_range(0, 6) == 0) ? TO - 1 : $urandom_range(0, 3);
  endfunction

  initial begin
    rst_n   = 1'b0;
    m_valid = '0;
    m_cmd   = '0;
    m_addr  = '0;
    m_wdata = '0;
    s_ack   = 1'b0;
    s_resp  = 1'b0;
    s_rdata = '0;
    modelReset();
    randomizeCells();
    doReset();

    // Directed single read from master 0
    randomizeCells();
    cellCmd[0]  = 1'b0;
    cellAddr[0] = 30'h10;
    slaveRdata  = 32'hDEADBEEF;
    applyStimulus(4'b0001, 0, 2, 2, 1'b1);

    // Rotation with everyone requesting, then only masters 1 and 3
    doReset();
    repeat (5) applyStimulus(4'b1111, 0, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    doReset();
    repeat (4) applyStimulus(4'b1010, 0, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);

    // Write completing with ack and resp together
    randomizeCells();
    for (int i = 0; i < M; i++) cellCmd[i] = 1'b1;
    applyStimulus(4'b1111, 1, 1, 0, 1'b1);

    // Watchdog cases and events coinciding with expiry
    applyStimulus(4'($urandom_range(1, 15)), 2, 0, 0, 1'b0);
    applyStimulus(4'b0100, 0, 1, 1, 1'b0);
    applyStimulus(4'($urandom_range(1, 15)), 0, 1, TO - 1, 1'b0);
    applyStimulus(4'($urandom_range(1, 15)), 0, TO - 1, 0, 1'b0);
    applyStimulus(4'($urandom_range(1, 15)), 3, 1, 0, 1'b0);

    // Reset while waiting for resp, then master 0 must win first
    applyStimulus(4'($urandom_range(1, 15)), 4, 1, 0, 1'b0);
    applyStimulus(4'b1111, 0, 1, 1, 1'b0);

    // Stray slave handshakes while idle
    for (int i = 0; i < 6; i++) begin
      s_ack  = 1'($urandom_range(0, 1));
      s_resp = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("idleIgnore", {busy, s_req, m_pop, ack_out, resp_out, err_out}, 64'd0);
    end
    s_ack  = 1'b0;
    s_resp = 1'b0;
    @(negedge clk);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      applyStimulus(4'($urandom_range(1, 15)), $urandom_range(0, 4), pickDelay(), pickDelay(), 1'b0);
    end

    repeat (3) @(negedge clk);
    checkOutput("queueEmpty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
